// File: rtl/dma_arbiter_pkg.sv
// rtl/dma_arbiter_pkg.sv - shared encodings for the Unibus memory-port arbiter
package dma_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CH0  = 2'd1,
    OWNER_CH1  = 2'd2,
    OWNER_CPU  = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin select, one-hot grant
// When both request, the channel not served last wins; otherwise the sole requester.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/dma_arbiter.sv
// rtl/dma_arbiter.sv - shares one Unibus memory port between the CPU and two NPR DMA channels
// DMA outranks the CPU, channels rotate, a burst limit reserves a CPU slot, a watchdog yields NXM.
module dma_arbiter
  import dma_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  dma_req,
  input  logic [1:0]  dma_we,
  input  logic [17:0] dma_addr0,
  input  logic [17:0] dma_addr1,
  input  logic [15:0] dma_wdata0,
  input  logic [15:0] dma_wdata1,
  output logic [1:0]  dma_ack,
  output logic [1:0]  dma_err,
  output logic [15:0] dma_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [17:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [17:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic [1:0]  owner
);

  localparam int BW = $clog2(MAX_BURST + 1);

  state_e        state;
  logic          rr_last;
  logic [BW-1:0] burst_cnt;
  logic [7:0]    wd_cnt;
  logic [1:0]    pick;
  logic          dma_go;
  logic          finish;

  rr_pick2 u_pick (
    .req   (dma_req),
    .last  (rr_last),
    .grant (pick)
  );

  // The CPU only pre-empts DMA once the burst allowance is used up while it waits.
  assign dma_go = (|dma_req) && !(cpu_req && (burst_cnt == BW'(MAX_BURST)));
  assign finish = mem_done || (wd_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
      wd_cnt    <= '0;
      dma_ack   <= '0;
      dma_err   <= '0;
      dma_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= OWNER_NONE;
    end else begin
      dma_ack <= '0;
      dma_err <= '0;
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dma_go) begin
            mem_req   <= 1'b1;
            wd_cnt    <= '0;
            state     <= ST_BUSY;
            rr_last   <= pick[1];
            owner     <= pick[1] ? OWNER_CH1 : OWNER_CH0;
            mem_we    <= pick[1] ? dma_we[1] : dma_we[0];
            mem_addr  <= pick[1] ? dma_addr1 : dma_addr0;
            mem_wdata <= pick[1] ? dma_wdata1 : dma_wdata0;
            if (!cpu_req) begin
              burst_cnt <= '0;
            end else if (burst_cnt != BW'(MAX_BURST)) begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end else if (cpu_req) begin
            mem_req   <= 1'b1;
            wd_cnt    <= '0;
            state     <= ST_BUSY;
            owner     <= OWNER_CPU;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            burst_cnt <= '0;
          end
        end
        ST_BUSY: begin
          wd_cnt <= wd_cnt + 8'd1;
          if (finish) begin
            mem_req   <= 1'b0;
            state     <= ST_ACK;
            dma_rdata <= mem_done ? mem_rdata : 16'd0;
            case (owner)
              OWNER_CH0: begin
                dma_ack <= 2'b01;
                dma_err <= {1'b0, !mem_done};
              end
              OWNER_CH1: begin
                dma_ack <= 2'b10;
                dma_err <= {!mem_done, 1'b0};
              end
              OWNER_CPU: begin
                cpu_ack <= 1'b1;
                cpu_err <= !mem_done;
              end
              default: ;
            endcase
          end
        end
        ST_ACK: begin
          owner <= OWNER_NONE;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// tb/tb_dma_arbiter.sv - self-checking bench for dma_arbiter
module tb_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dma_req, dma_we, dma_ack, dma_err;
  logic [17:0] dma_addr0, dma_addr1, cpu_addr, mem_addr;
  logic [15:0] dma_wdata0, dma_wdata1, dma_rdata, cpu_wdata, mem_wdata, mem_rdata;
  logic        cpu_req, cpu_we, cpu_ack, cpu_err;
  logic        mem_req, mem_we, mem_done;
  logic [1:0]  owner;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: which channel was served most recently, and how many DMA
  // grants in a row went by while the CPU was left waiting.
  bit m_last_ch1 = 1'b1;
  int m_waits    = 0;

  always #5 clk = ~clk;

  dma_arbiter dut (
    .clk(clk), .reset(reset),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr0(dma_addr0), .dma_addr1(dma_addr1),
    .dma_wdata0(dma_wdata0), .dma_wdata1(dma_wdata1),
    .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int predict();
    if (dma_req != 2'b00 && !(cpu_req && m_waits >= 4)) begin
      if (dma_req == 2'b11) return m_last_ch1 ? 1 : 2;
      return dma_req[0] ? 1 : 2;
    end
    if (cpu_req) return 3;
    return 0;
  endfunction

  // One complete transaction: grant, memory response after lat cycles (0 = never), ack.
  task automatic txn(input string tag, input int exp_w, input int lat, input bit drop,
                     input logic [15:0] rd);
    int c;
    bit done_ok;
    logic [17:0] ea;
    logic        ewe;
    logic [15:0] ed;
    case (exp_w)
      1:       begin ea = dma_addr0; ewe = dma_we[0]; ed = dma_wdata0; end
      2:       begin ea = dma_addr1; ewe = dma_we[1]; ed = dma_wdata1; end
      default: begin ea = cpu_addr;  ewe = cpu_we;    ed = cpu_wdata;  end
    endcase
    c = 0;
    while (mem_req !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({tag, " latency"}, c, 1);
    chk({tag, " owner"}, owner, exp_w);
    chk({tag, " mem_addr"}, mem_addr, ea);
    chk({tag, " mem_we"}, mem_we, ewe);
    chk({tag, " mem_wdata"}, mem_wdata, ed);
    if (exp_w == 3) begin
      m_waits = 0;
    end else begin
      m_last_ch1 = (exp_w == 2);
      m_waits = cpu_req ? ((m_waits < 4) ? m_waits + 1 : 4) : 0;
    end
    c = 1;
    while (1) begin
      if (drop && c == 1) dma_req = 2'b00;
      mem_done = (c == lat);
      mem_rdata = rd;
      @(negedge clk);
      mem_done = 1'b0;
      mem_rdata = $urandom;
      if (dma_ack != 2'b00 || cpu_ack) break;
      if (c >= 300) break;
      c++;
    end
    done_ok = (lat > 0 && lat <= 255);
    chk({tag, " busy cycles"}, c, done_ok ? lat : 255);
    chk({tag, " mem_req dropped"}, mem_req, 0);
    chk({tag, " dma_ack"}, dma_ack, {exp_w == 2, exp_w == 1});
    chk({tag, " cpu_ack"}, cpu_ack, exp_w == 3);
    chk({tag, " dma_err"}, dma_err, {exp_w == 2 && !done_ok, exp_w == 1 && !done_ok});
    chk({tag, " cpu_err"}, cpu_err, exp_w == 3 && !done_ok);
    chk({tag, " rdata"}, dma_rdata, done_ok ? rd : 16'd0);
    @(negedge clk);
    chk({tag, " ack pulse width"}, {dma_ack, cpu_ack}, 0);
  endtask

  initial begin
    int seen;
    int w;
    reset = 1'b1;
    dma_req = 0; dma_we = 0; dma_addr0 = 0; dma_addr1 = 0; dma_wdata0 = 0; dma_wdata1 = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; mem_rdata = 0; mem_done = 0;
    repeat (3) @(negedge clk);
    chk("reset ctrl", {mem_req, owner, dma_ack, dma_err, cpu_ack, cpu_err, mem_we}, 0);
    chk("reset data", {mem_addr, dma_rdata}, 0);
    chk("reset wdata", mem_wdata, 0);
    reset = 1'b0;

    // round robin: both channels, no CPU
    dma_req = 2'b11; dma_we = 2'b01;
    dma_addr0 = 18'o000100; dma_addr1 = 18'o000201;
    dma_wdata0 = 16'h1111; dma_wdata1 = 16'h2222;
    txn("rr1", 1, 2, 0, $urandom);
    txn("rr2", 2, 2, 0, $urandom);
    txn("rr3", 1, 2, 0, $urandom);
    txn("rr4", 2, 2, 0, $urandom);
    dma_req = 2'b00;

    // single channel read
    dma_req = 2'b01; dma_we = 2'b00; dma_addr0 = 18'o001000;
    txn("rd0", 1, 3, 0, 16'o123456);
    dma_req = 2'b00;

    // CPU starvation guard
    dma_req = 2'b01; dma_we = 2'b01; cpu_req = 1'b1; cpu_addr = 18'o017776; cpu_wdata = 16'hbeef;
    txn("burst1", 1, 1, 0, $urandom);
    txn("burst2", 1, 1, 0, $urandom);
    txn("burst3", 1, 1, 0, $urandom);
    txn("burst4", 1, 1, 0, $urandom);
    txn("burst cpu", 3, 2, 0, $urandom);
    cpu_req = 1'b0;
    txn("burst resume", 1, 1, 0, $urandom);
    dma_req = 2'b00;

    // NXM on CPU access
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'o777776;
    txn("nxm", 3, 0, 0, 16'hdead);
    cpu_req = 1'b0;

    // mem_done coincides with timeout
    dma_req = 2'b01; dma_we = 2'b00; dma_addr0 = 18'o002001;
    txn("edge done", 1, 255, 0, 16'h5a5a);
    dma_req = 2'b00;

    // requester drops req mid-transaction
    dma_req = 2'b10; dma_addr1 = 18'o003000; dma_we = 2'b00;
    txn("drop", 2, 4, 1, 16'hc0de);

    // reset mid-busy
    dma_req = 2'b01;
    seen = 0;
    while (mem_req !== 1'b1 && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk("rst busy grant", mem_req, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst busy outs", {mem_req, owner, dma_ack, cpu_ack, dma_err, cpu_err}, 0);
    chk("rst busy addr", mem_addr, 0);
    reset = 1'b0; dma_req = 2'b00;
    m_last_ch1 = 1'b1; m_waits = 0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (dma_ack != 0 || cpu_ack || mem_req) seen++;
    end
    chk("rst busy quiet", seen, 0);
    dma_req = 2'b10; dma_addr1 = 18'o004002; dma_wdata1 = 16'h7777; dma_we = 2'b10;
    txn("rst ch1", 2, 2, 0, $urandom);
    dma_req = 2'b00;

    // randomized traffic against the model
    for (int i = 0; i < 20; i++) begin
      dma_req = 2'($urandom_range(0, 3));
      cpu_req = 1'($urandom_range(0, 1));
      if (dma_req == 2'b00) cpu_req = 1'b1;
      dma_we = 2'($urandom); cpu_we = 1'($urandom);
      dma_addr0 = 18'($urandom); dma_addr1 = 18'($urandom); cpu_addr = 18'($urandom);
      dma_wdata0 = 16'($urandom); dma_wdata1 = 16'($urandom); cpu_wdata = 16'($urandom);
      w = predict();
      txn($sformatf("rand%0d", i), w, $urandom_range(1, 6), 0, 16'($urandom));
    end
    dma_req = 2'b00; cpu_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
